imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 124 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Decodes the RISC-V immediate of an instruction into a sign-extended value
//   of width XLEN. The result is registered, with one extra skid entry, so
//   in_ready is a pure register output.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input handshake valid
//   in_ready     input handshake ready (registered, equal to NOT skid full)
//   in_instr     instruction bits [31:7]; port bit k is instruction bit k+7
//   in_src       immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 5..7 illegal
//   out_valid    out_imm / out_illegal hold a result
//   out_ready    downstream accepts the result
//   out_imm      sign-extended immediate (zero for an illegal select)
//   out_illegal  result came from an illegal select
//   illegal_cnt  saturating count of accepted illegal selects
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_U = 3'd3;
    localparam logic [2:0] SRC_J = 3'd4;

    // Renumbered so the decode reads in instruction bit positions.
    logic [31:7]     instr;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    assign instr = in_instr;

    always_comb begin
        imm32       = '0;
        dec_illegal = 1'b0;
        case (in_src)
            SRC_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            SRC_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SRC_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            SRC_U:   imm32 = {instr[31:12], 12'h000};
            SRC_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            default: dec_illegal = 1'b1;
        endcase
    end

    // Every 32-bit form already carries instr[31] in bit 31, so widening
    // only needs to replicate that bit.
    generate
        if (XLEN > 32) begin : g_wide
            assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign dec_imm = imm32;
        end
    endgenerate

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic            skid_illegal;
    logic            accept;
    logic            out_free;

    assign accept   = in_valid & in_ready;
    // Output register can take a new value at this edge.
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
            in_ready     <= 1'b1;
        end else if (out_free) begin
            // A full skid implies in_ready=0, so no acceptance competes here.
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_illegal <= dec_illegal;
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_illegal <= dec_illegal;
            in_ready     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Directed table of decode vectors applied to a 32-bit and a 64-bit
//   instance, followed by backpressure, illegal-count, reset and randomised
//   handshake sequences on the 32-bit instance.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, 2-bit counter
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [24:0] a_in_instr;
    logic [2:0]  a_in_src;
    logic [31:0] a_out_imm;
    logic [1:0]  a_cnt;

    // 64-bit instance, default counter
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [24:0] b_in_instr;
    logic [2:0]  b_in_src;
    logic [63:0] b_out_imm;
    logic [7:0]  b_cnt;

    imm_extend_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_src(a_in_src),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_imm(a_out_imm), .out_illegal(a_out_illegal),
        .illegal_cnt(a_cnt)
    );

    imm_extend_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_src(b_in_src),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_illegal(b_out_illegal),
        .illegal_cnt(b_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        illegal;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic        illegal;
    } res_t;

    vec_t vecs[13];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] instr, input logic [2:0] src);
        logic [31:0] t;
        t = instr;
        a_in_valid = v;
        a_in_instr = t[31:7];
        a_in_src   = src;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] held_imm;
        logic        held;
        logic [31:0] t;
        res_t        q[$];
        res_t        r;
        int          idx;

        vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2]  = '{32'hFFDFF06F, 3'd4, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[4]  = '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[5]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[6]  = '{32'h00000463, 3'd2, 32'h00000008, 64'h0000000000000008, 1'b0};
        vecs[7]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[8]  = '{32'h020000A3, 3'd1, 32'h00000021, 64'h0000000000000021, 1'b0};
        vecs[9]  = '{32'h0010006F, 3'd4, 32'h00000800, 64'h0000000000000800, 1'b0};
        vecs[10] = '{32'h0000106F, 3'd4, 32'h00001000, 64'h0000000000001000, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 3'd5, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[12] = '{32'h12345678, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};

        drive_a(1'b0, 32'h0, 3'd0);
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_instr = '0; b_in_src = '0; b_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_imm", a_out_imm, 0);
        check("rst_out_illegal", a_out_illegal, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_out_imm64", b_out_imm, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode table, back-to-back with out_ready=1
        foreach (vecs[i]) begin
            check("tbl_in_ready", a_in_ready, 1);
            drive_a(1'b1, vecs[i].instr, vecs[i].src);
            t = vecs[i].instr;
            b_in_valid = 1'b1; b_in_instr = t[31:7]; b_in_src = vecs[i].src;
            step();
            check($sformatf("tbl%0d_valid32", i), a_out_valid, 1);
            check($sformatf("tbl%0d_imm32", i), a_out_imm, vecs[i].exp32);
            check($sformatf("tbl%0d_ill32", i), a_out_illegal, vecs[i].illegal);
            check($sformatf("tbl%0d_imm64", i), b_out_imm, vecs[i].exp64);
            check($sformatf("tbl%0d_ill64", i), b_out_illegal, vecs[i].illegal);
        end
        drive_a(1'b0, 32'h0, 3'd0);
        b_in_valid = 1'b0;
        step();
        check("tbl_drain_valid", a_out_valid, 0);
        check("tbl_cnt64", b_cnt, 2);

        // Backpressure: three back-to-back inputs with out_ready=0
        a_out_ready = 1'b0;
        drive_a(1'b1, vecs[0].instr, vecs[0].src);
        step();
        check("bp_first_valid", a_out_valid, 1);
        check("bp_first_ready", a_in_ready, 1);
        drive_a(1'b1, vecs[3].instr, vecs[3].src);
        step();
        check("bp_second_ready", a_in_ready, 0);
        check("bp_second_hold", a_out_imm, vecs[0].exp32);
        drive_a(1'b1, vecs[7].instr, vecs[7].src);
        step();
        check("bp_third_blocked", a_in_ready, 0);
        check("bp_stall_imm", a_out_imm, vecs[0].exp32);
        check("bp_stall_valid", a_out_valid, 1);
        a_out_ready = 1'b1;
        step();
        check("bp_out_second", a_out_imm, vecs[3].exp32);
        check("bp_ready_back", a_in_ready, 1);
        step();
        check("bp_out_third", a_out_imm, vecs[7].exp32);
        check("bp_third_valid", a_out_valid, 1);
        drive_a(1'b0, 32'h0, 3'd0);
        step();
        check("bp_empty", a_out_valid, 0);

        // Illegal-select counting with saturation at 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b1, 32'hDEADBEEF, 3'd6);
            step();
            check($sformatf("ill%0d_imm", k), a_out_imm, 0);
            check($sformatf("ill%0d_flag", k), a_out_illegal, 1);
            check($sformatf("ill%0d_cnt", k), a_cnt, (k < 3) ? k + 1 : 3);
        end
        drive_a(1'b0, 32'h0, 3'd0);
        step();

        // Asynchronous reset with both stages full
        a_out_ready = 1'b0;
        drive_a(1'b1, vecs[11].instr, vecs[11].src);
        step();
        drive_a(1'b1, vecs[1].instr, vecs[1].src);
        step();
        drive_a(1'b0, 32'h0, 3'd0);
        check("pre_rst_full", a_in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 0);
        check("arst_in_ready", a_in_ready, 1);
        check("arst_cnt", a_cnt, 0);
        check("arst_imm", a_out_imm, 0);
        step();
        #2 rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_no_stale", a_out_valid, 0);
        end
        // First acceptance right after release, 1-cycle latency
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1'b1, vecs[8].instr, vecs[8].src);
        step();
        check("first_edge_valid", a_out_valid, 1);
        check("first_edge_imm", a_out_imm, vecs[8].exp32);
        drive_a(1'b0, 32'h0, 3'd0);
        step();

        // Random handshake against a reference queue
        held = 1'b0;
        held_imm = '0;
        for (int c = 0; c < 10000; c++) begin
            if (held) begin
                check("rnd_stall_valid", a_out_valid, 1);
                check("rnd_stall_imm", a_out_imm, held_imm);
            end
            check("rnd_out_valid", a_out_valid, (q.size() != 0) ? 1 : 0);
            check("rnd_in_ready", a_in_ready, (q.size() < 2) ? 1 : 0);
            idx = $urandom_range(0, 12);
            drive_a(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, vecs[idx].instr, vecs[idx].src);
            a_out_ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            #1;
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 1, 0);
                end else begin
                    r = q.pop_front();
                    check("rnd_imm", a_out_imm, r.imm);
                    check("rnd_illegal", a_out_illegal, r.illegal);
                end
            end
            if (a_in_valid && a_in_ready)
                q.push_back('{vecs[idx].exp32, vecs[idx].illegal});
            held = a_out_valid && !a_out_ready;
            held_imm = a_out_imm;
            step();
        end
        drive_a(1'b0, 32'h0, 3'd0);
        a_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (a_out_valid) begin
                if (q.size() == 0) begin
                    check("drain_unexpected_out", 1, 0);
                end else begin
                    r = q.pop_front();
                    check("drain_imm", a_out_imm, r.imm);
                end
            end
            step();
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_out_valid", a_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
